// File: rtl/alarm_time_unit.sv
// Alarm time storage, arming and ring/snooze sequencer for a BCD alarm clock.
// Optional snooze support is built in when macro ALARM_SNOOZE_EN is defined.
module alarm_time_unit #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ALM_ONOFF,
    input  logic       ALM_HOUR,
    input  logic       ALM_MIN,
    input  logic       SEC_TICK,
    input  logic [7:0] CUR_HOUR,
    input  logic [7:0] CUR_MIN,
    input  logic [7:0] CUR_SEC,
    input  logic       ALM_STOP,
    input  logic       SNOOZE,
    output logic       ALM_EN,
    output logic [7:0] ALM_HOUR_BCD,
    output logic [7:0] ALM_MIN_BCD,
    output logic       ALARM
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    localparam logic [7:0] RING_LOAD = 8'(RING_SECS);

    // BCD increment with wrap at the given maximum value
    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [4:0] req, req_q, ev;
    logic       onoff_ev, hour_ev, min_ev, stop_ev, snooze_ev;
    logic       disarm, sec_zero_tick, alarm_hit;
    logic [1:0] state, state_d;
    logic [7:0] ring_cnt, cnt_d;

    assign req       = {ALM_ONOFF, ALM_HOUR, ALM_MIN, ALM_STOP, SNOOZE};
    assign ev        = req & ~req_q;
    assign onoff_ev  = ev[4];
    assign hour_ev   = ev[3];
    assign min_ev    = ev[2];
    assign stop_ev   = ev[1];
    assign snooze_ev = ev[0];

    // An on/off event while armed clears ALM_EN and overrides every transition
    assign disarm        = onoff_ev & ALM_EN;
    assign sec_zero_tick = SEC_TICK & (CUR_SEC == 8'h00);
    assign alarm_hit     = ALM_EN & sec_zero_tick &
                           (CUR_HOUR == ALM_HOUR_BCD) & (CUR_MIN == ALM_MIN_BCD);

`ifdef ALARM_SNOOZE_EN
    logic [7:0] snz_hour_q, snz_min_q;
    logic [7:0] snz_hour_d, snz_min_d;
    logic [7:0] cur_hour_bin, cur_min_bin, sum_min, sum_hour;
    logic       snooze_hit, snz_load;

    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [7:0] b);
        logic [7:0] tens;
        tens = b / 8'd10;
        return {tens[3:0], 4'(b - tens * 8'd10)};
    endfunction

    // Snooze target: current time plus SNOOZE_MIN, carrying into the hour, 23:59 -> 00:00
    always_comb begin
        cur_hour_bin = bcd2bin(CUR_HOUR);
        cur_min_bin  = bcd2bin(CUR_MIN);
        sum_min      = cur_min_bin + 8'(SNOOZE_MIN);
        sum_hour     = cur_hour_bin;
        if (sum_min >= 8'd60) begin
            sum_min  = sum_min - 8'd60;
            sum_hour = cur_hour_bin + 8'd1;
        end
        if (sum_hour >= 8'd24)
            sum_hour = 8'd0;
        snz_hour_d = bin2bcd(sum_hour);
        snz_min_d  = bin2bcd(sum_min);
    end

    assign snooze_hit = ALM_EN & sec_zero_tick &
                        (CUR_HOUR == snz_hour_q) & (CUR_MIN == snz_min_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snz_hour_q <= 8'h00;
            snz_min_q  <= 8'h00;
        end else if (snz_load) begin
            snz_hour_q <= snz_hour_d;
            snz_min_q  <= snz_min_d;
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = snooze_ev & (SNOOZE_MIN > 0);
`endif

    always_comb begin
        state_d = state;
        cnt_d   = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_load = 1'b0;
`endif
        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (alarm_hit) begin
                        state_d = ST_RING;
                        cnt_d   = RING_LOAD;
                    end
                end
                ST_RING: begin
                    // Stop is checked first so it wins over a coincident snooze
                    if (stop_ev) begin
                        state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze_ev) begin
                        state_d  = ST_SNOOZE;
                        snz_load = 1'b1;
`endif
                    end else if (SEC_TICK) begin
                        cnt_d = ring_cnt - 8'd1;
                        if (ring_cnt <= 8'd1)
                            state_d = ST_IDLE;
                    end
                end
                ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (stop_ev) begin
                        state_d = ST_IDLE;
                    end else if (snooze_hit) begin
                        state_d = ST_RING;
                        cnt_d   = RING_LOAD;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q        <= 5'b0;
            ALM_EN       <= 1'b0;
            ALM_HOUR_BCD <= 8'h00;
            ALM_MIN_BCD  <= 8'h00;
            state        <= ST_IDLE;
            ring_cnt     <= 8'd0;
        end else begin
            req_q <= req;
            if (onoff_ev)
                ALM_EN <= ~ALM_EN;
            if (hour_ev)
                ALM_HOUR_BCD <= inc_bcd(ALM_HOUR_BCD, 8'h23);
            if (min_ev)
                ALM_MIN_BCD <= inc_bcd(ALM_MIN_BCD, 8'h59);
            state    <= state_d;
            ring_cnt <= cnt_d;
        end
    end

    // Decoded straight from the async-reset state so reset drops it at once
    assign ALARM = (state == ST_RING);

endmodule

// File: tb/tb_alarm_time_unit.sv
// Bench for alarm_time_unit: directed scenarios plus random traffic checked
// against a minute-count reference model.
module tb_alarm_time_unit;

    localparam int RS = 3;
    localparam int SM = 5;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ALM_ONOFF = 1'b0, ALM_HOUR = 1'b0, ALM_MIN = 1'b0, SEC_TICK = 1'b0;
    logic       ALM_STOP = 1'b0, SNOOZE = 1'b0;
    logic [7:0] CUR_HOUR = 8'h00, CUR_MIN = 8'h00, CUR_SEC = 8'h00;
    logic       ALM_EN, ALARM;
    logic [7:0] ALM_HOUR_BCD, ALM_MIN_BCD;

    always #5 clock = ~clock;

    alarm_time_unit #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clock(clock), .reset(reset),
        .ALM_ONOFF(ALM_ONOFF), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
        .SEC_TICK(SEC_TICK), .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
        .ALM_STOP(ALM_STOP), .SNOOZE(SNOOZE),
        .ALM_EN(ALM_EN), .ALM_HOUR_BCD(ALM_HOUR_BCD), .ALM_MIN_BCD(ALM_MIN_BCD),
        .ALARM(ALARM)
    );

    int    n_chk = 0, n_pass = 0;
    string phase = "reset";

    // Reference model: alarm time as plain integers, state 0 idle / 1 ring / 2 snooze
    bit m_en;
    int m_h, m_m, m_state, m_cnt, m_tgt;
    bit p_on, p_h, p_m, p_st, p_sn;
    int t_h, t_m, t_s;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %h expected %h", phase, tag, obs, exp);
    endtask

    task automatic check_all();
        check("alm_en", 8'(ALM_EN), 8'(m_en));
        check("alm_hour", ALM_HOUR_BCD, bcd(m_h));
        check("alm_min", ALM_MIN_BCD, bcd(m_m));
        check("alarm", 8'(ALARM), 8'(m_state == 1));
    endtask

    task automatic model_reset();
        m_en = 0; m_h = 0; m_m = 0; m_state = 0; m_cnt = 0; m_tgt = 0;
        p_on = 0; p_h = 0; p_m = 0; p_st = 0; p_sn = 0;
    endtask

    task automatic model_step();
        bit e_on, e_h, e_m, e_st, e_sn, disarm, hit;
        int now;
        e_on = ALM_ONOFF && !p_on; e_h = ALM_HOUR && !p_h; e_m = ALM_MIN && !p_m;
        e_st = ALM_STOP && !p_st;  e_sn = SNOOZE && !p_sn;
        p_on = ALM_ONOFF; p_h = ALM_HOUR; p_m = ALM_MIN; p_st = ALM_STOP; p_sn = SNOOZE;
        now    = t_h * 60 + t_m;
        disarm = e_on && m_en;
        hit    = m_en && SEC_TICK && t_s == 0 && t_h == m_h && t_m == m_m;
        if (disarm) m_state = 0;
        else case (m_state)
            0: if (hit) begin m_state = 1; m_cnt = RS; end
            1: if (e_st) m_state = 0;
               else if (SNZ && e_sn) begin m_state = 2; m_tgt = (now + SM) % 1440; end
               else if (SEC_TICK) begin m_cnt--; if (m_cnt == 0) m_state = 0; end
            default: if (e_st) m_state = 0;
               else if (m_en && SEC_TICK && t_s == 0 && now == m_tgt) begin
                   m_state = 1; m_cnt = RS;
               end
        endcase
        if (e_on) m_en = !m_en;
        if (e_h)  m_h = (m_h + 1) % 24;
        if (e_m)  m_m = (m_m + 1) % 60;
    endtask

    task automatic drive_time(input int h, input int m, input int s);
        t_h = h; t_m = m; t_s = s;
        CUR_HOUR = bcd(h); CUR_MIN = bcd(m); CUR_SEC = bcd(s);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_req();
        ALM_ONOFF = 0; ALM_HOUR = 0; ALM_MIN = 0; ALM_STOP = 0; SNOOZE = 0; SEC_TICK = 0;
    endtask

    // which: 0 onoff, 1 hour, 2 min, 3 stop, 4 snooze
    task automatic pulse(input int which);
        case (which)
            0: ALM_ONOFF = 1;
            1: ALM_HOUR = 1;
            2: ALM_MIN = 1;
            3: ALM_STOP = 1;
            default: SNOOZE = 1;
        endcase
        cyc();
        clear_req();
        cyc();
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        drive_time(h, m, s);
        SEC_TICK = 1;
        cyc();
        SEC_TICK = 0;
    endtask

    task automatic set_alarm(input int h, input int m);
        while (m_h != h) pulse(1);
        while (m_m != m) pulse(2);
        if (!m_en) pulse(0);
    endtask

    initial begin
        model_reset();
        drive_time(0, 0, 0);
        #12;
        check_all();
        check("rst_alarm", 8'(ALARM), 8'h00);
        reset = 0;
        cyc();

        phase = "hour_walk";
        for (int i = 0; i < 24; i++) begin
            pulse(1);
            check("hour_step", ALM_HOUR_BCD, bcd((i + 1) % 24));
        end

        phase = "min_walk";
        for (int i = 0; i < 60; i++) begin
            pulse(2);
            check("min_step", ALM_MIN_BCD, bcd((i + 1) % 60));
        end
        check("hour_kept", ALM_HOUR_BCD, 8'h00);

        phase = "hold";
        ALM_HOUR = 1;
        repeat (10) cyc();
        ALM_HOUR = 0;
        cyc();
        check("hold_once", ALM_HOUR_BCD, 8'h01);

        phase = "ring";
        set_alarm(7, 30);
        check("armed", 8'(ALM_EN), 8'h01);
        tick_at(7, 29, 59);
        check("pre_ring", 8'(ALARM), 8'h00);
        tick_at(7, 30, 0);
        check("ring_on", 8'(ALARM), 8'h01);
        tick_at(7, 30, 1);
        tick_at(7, 30, 2);
        check("ring_t2", 8'(ALARM), 8'h01);
        tick_at(7, 30, 3);
        check("ring_end", 8'(ALARM), 8'h00);

        phase = "stop_snooze";
        tick_at(7, 30, 0);
        check("ring_again", 8'(ALARM), 8'h01);
        ALM_STOP = 1; SNOOZE = 1;
        cyc();
        clear_req();
        check("stop_wins", 8'(ALARM), 8'h00);
        for (int s = 1; s < 60; s++) tick_at(7, 30, s);
        check("no_rering", 8'(ALARM), 8'h00);

        phase = "snooze";
        set_alarm(23, 58);
        tick_at(23, 58, 0);
        check("snz_ring", 8'(ALARM), 8'h01);
        drive_time(23, 58, 10);
        pulse(4);
`ifdef ALARM_SNOOZE_EN
        check("snz_quiet", 8'(ALARM), 8'h00);
        tick_at(0, 2, 59);
        check("snz_wait", 8'(ALARM), 8'h00);
        tick_at(0, 3, 0);
        check("snz_rering", 8'(ALARM), 8'h01);
`else
        check("snz_ignored", 8'(ALARM), 8'h01);
`endif
        pulse(3);
        check("snz_stopped", 8'(ALARM), 8'h00);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            int sel;
            ALM_ONOFF = ($urandom_range(0, 15) == 0);
            ALM_HOUR  = ($urandom_range(0, 9) == 0);
            ALM_MIN   = ($urandom_range(0, 9) == 0);
            ALM_STOP  = ($urandom_range(0, 11) == 0);
            SNOOZE    = ($urandom_range(0, 5) == 0);
            SEC_TICK  = ($urandom_range(0, 1) == 0);
            sel = int'($urandom_range(0, 7));
            if (sel < 3)       drive_time(m_h, m_m, 0);
            else if (sel == 3) drive_time(m_tgt / 60, m_tgt % 60, 0);
            else drive_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                            int'($urandom_range(0, 2)) == 0 ? 0 : int'($urandom_range(0, 59)));
            cyc();
        end
        clear_req();
        cyc();
        pulse(3);

        phase = "async_reset";
        set_alarm(7, 30);
        tick_at(7, 30, 0);
        check("pre_rst_ring", 8'(ALARM), 8'h01);
        #2 reset = 1;
        #1;
        model_reset();
        check("rst_alarm_now", 8'(ALARM), 8'h00);
        check("rst_en_now", 8'(ALM_EN), 8'h00);
        check_all();
        @(negedge clock);
        reset = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_time_unit.md
ALARM_TIME_UNIT -- requirements
Module: alarm_time_unit

Interface
REQ-001 Parameter RING_SECS, default 60: ring duration in SEC_TICK pulses, legal range 1..255.
REQ-002 Parameter SNOOZE_MIN, default 5: snooze delay in minutes, legal range 1..59; used only with ALARM_SNOOZE_EN.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be exactly as follows.
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ALM_ONOFF  in  1  alarm on/off toggle request from the alarm control FSM.
REQ-007 ALM_HOUR  in  1  alarm-hour increment request from the alarm control FSM.
REQ-008 ALM_MIN  in  1  alarm-minute increment request from the alarm control FSM.
REQ-009 SEC_TICK  in  1  one-cycle 1 Hz pulse from the timekeeper.
REQ-010 CUR_HOUR  in  8  current hour, BCD 00..23.
REQ-011 CUR_MIN  in  8  current minute, BCD 00..59.
REQ-012 CUR_SEC  in  8  current second, BCD 00..59.
REQ-013 ALM_STOP  in  1  stop-ringing request.
REQ-014 SNOOZE  in  1  snooze request; ignored without ALARM_SNOOZE_EN.
REQ-015 ALM_EN  out  1  alarm armed.
REQ-016 ALM_HOUR_BCD  out  8  stored alarm hour, BCD.
REQ-017 ALM_MIN_BCD  out  8  stored alarm minute, BCD.
REQ-018 ALARM  out  1  ringing indicator.

Function
REQ-019 ALM_ONOFF, ALM_HOUR, ALM_MIN, ALM_STOP and SNOOZE SHALL each be rising-edge detected against a registered previous value; a level held high SHALL count as one event.
REQ-020 Each event SHALL be acted on at the rising clock edge where input=1 and previous value=0; the updated output SHALL be visible from that edge onward (one cycle after the input rises).
REQ-021 An ALM_HOUR event SHALL increment ALM_HOUR_BCD in BCD, wrapping 23 to 00.
REQ-022 An ALM_MIN event SHALL increment ALM_MIN_BCD in BCD, wrapping 59 to 00, with no carry into the hour.
REQ-023 Simultaneous ALM_HOUR and ALM_MIN events SHALL both be applied in the same cycle.
REQ-024 An ALM_ONOFF event SHALL toggle ALM_EN.
REQ-025 The FSM SHALL have states IDLE, RING and SNOOZE; ALARM SHALL be 1 exactly when the state is RING.
REQ-026 IDLE to RING SHALL occur on a cycle with ALM_EN=1, SEC_TICK=1, CUR_SEC=00, CUR_HOUR=ALM_HOUR_BCD and CUR_MIN=ALM_MIN_BCD; entering RING SHALL load the ring counter with RING_SECS.
REQ-027 In RING, each SEC_TICK SHALL decrement the ring counter; the tick that reaches 0 SHALL return the FSM to IDLE.
REQ-028 From RING, an ALM_STOP event SHALL return the FSM to IDLE on the next edge; the alarm SHALL NOT re-trigger within the same minute.
REQ-029 Clearing ALM_EN (ALM_ONOFF event) in RING or SNOOZE SHALL force IDLE in the same edge.
REQ-030 ALM_HOUR/ALM_MIN edits during RING SHALL update storage but SHALL NOT stop ringing.
REQ-031 If ALM_STOP and SNOOZE events coincide, ALM_STOP SHALL take priority.

Reset
REQ-032 On reset, asynchronously: ALM_EN=0, ALM_HOUR_BCD=8'h00, ALM_MIN_BCD=8'h00, ALARM=0, state=IDLE, ring counter=0, snooze target=00:00, all edge-detect registers=0.
REQ-033 Reset asserted during RING SHALL clear ALARM immediately, without waiting for a clock edge.

Configuration
REQ-034 With macro ALARM_SNOOZE_EN defined, a SNOOZE event in RING SHALL enter SNOOZE and latch snooze target = current time + SNOOZE_MIN minutes (BCD, wrapping minutes into hours and 23:59 to 00:00).
REQ-035 With ALARM_SNOOZE_EN defined, SNOOZE SHALL go to RING (reloading RING_SECS) on the REQ-026 match condition against the snooze target, and to IDLE on an ALM_STOP event.
REQ-036 Without ALARM_SNOOZE_EN, the SNOOZE port SHALL be present but ignored, and the SNOOZE state SHALL be unreachable.

Verification
REQ-037 Reset, then 24 ALM_HOUR pulses -> ALM_HOUR_BCD steps 00..23 and then 00; 60 ALM_MIN pulses -> 00..59 and then 00; ALM_HOUR unchanged.
REQ-038 ALM_HOUR held high for 10 cycles -> exactly one increment.
REQ-039 Armed alarm 07:30, current time 07:30:00 with SEC_TICK -> ALARM=1 on the next edge; with RING_SECS=3, ALARM=0 after the 3rd following tick.
REQ-040 Ringing, then ALM_STOP and SNOOZE pulsed in the same cycle -> IDLE, ALARM=0, no re-ring at 07:30:01..59.
REQ-041 ALARM_SNOOZE_EN defined, alarm 23:58, SNOOZE at 23:58:10 -> ALARM=0, re-ring at 00:03:00.
REQ-042 Reset asserted mid-ring between clock edges -> ALARM=0 and ALM_EN=0 immediately.
